// File: rtl/traffic_phase_fsm_pkg.sv
// Shared types and constants for the intersection phase controller:
// phase encodings, lamp codes and the seconds-counter width.
package traffic_phase_fsm_pkg;

    localparam int CNT_W   = 6;
    localparam int CNT_TOP = 63;

    typedef enum logic [2:0] {
        ALL_RED_A = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALL_RED_B = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        FLASH     = 3'd6
    } phase_t;

    // Lamp word is {red, yellow, green}.
    typedef logic [2:0] lamp_t;
    localparam lamp_t LAMP_RED = 3'b100;
    localparam lamp_t LAMP_YEL = 3'b010;
    localparam lamp_t LAMP_GRN = 3'b001;
    localparam lamp_t LAMP_OFF = 3'b000;

    function automatic bit dur_valid(input int d);
        return (d >= 1) && (d <= CNT_TOP);
    endfunction

endpackage

// File: rtl/traffic_phase_fsm_if.sv
// Signal bundle between the timer stage / request inputs and the phase controller.
// The controller takes the slave side; whatever drives ticks and requests takes master.
interface traffic_phase_fsm_if;
    import traffic_phase_fsm_pkg::*;

    logic       one_sec;
    logic       half_sec;
    logic       ped_req_ns;
    logic       ped_req_ew;
    logic       ew_car;
    logic       flash_mode;
    lamp_t      ns_lamp;
    lamp_t      ew_lamp;
    logic       walk_ns;
    logic       walk_ew;
    logic [2:0] phase;

    modport master (
        output one_sec, half_sec, ped_req_ns, ped_req_ew, ew_car, flash_mode,
        input  ns_lamp, ew_lamp, walk_ns, walk_ew, phase
    );

    modport slave (
        input  one_sec, half_sec, ped_req_ns, ped_req_ew, ew_car, flash_mode,
        output ns_lamp, ew_lamp, walk_ns, walk_ew, phase
    );

endinterface

// File: rtl/traffic_phase_fsm_phase_timer.sv
// Seconds spent in the current phase: counts one_sec ticks, saturates at the top
// of the counter, and restarts from zero whenever the controller changes phase.
module traffic_phase_fsm_phase_timer
    import traffic_phase_fsm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             tick,
    output logic [CNT_W-1:0] sec_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_TOP);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sec_cnt <= '0;
        end else if (tick && (sec_cnt != CNT_MAX)) begin
            sec_cnt <= sec_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_fsm.sv
// Two-way intersection phase controller: NS/EW green-yellow-red sequencing with
// pedestrian walk service, an EW car sensor and a flashing fault/night mode.
module traffic_phase_fsm
    import traffic_phase_fsm_pkg::*;
#(
    parameter int GREEN_TIME   = 20,
    parameter int MIN_GREEN    = 5,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 1,
    parameter int WALK_TIME    = 7
) (
    input  logic clk,
    input  logic reset,
    traffic_phase_fsm_if.slave bus
);

    // A walk longer than the NS minimum green is allowed: it is simply cut off
    // when the green ends, so walk can never show outside its own green.
    if (!(dur_valid(GREEN_TIME) && dur_valid(MIN_GREEN) && dur_valid(YELLOW_TIME) &&
          dur_valid(ALL_RED_TIME) && dur_valid(WALK_TIME) &&
          (MIN_GREEN <= GREEN_TIME) && (WALK_TIME <= GREEN_TIME))) begin : g_bad_timing
        $error("traffic_phase_fsm: illegal timing parameters");
    end

    localparam logic [CNT_W:0] GREEN_T   = (CNT_W+1)'(GREEN_TIME);
    localparam logic [CNT_W:0] MIN_T     = (CNT_W+1)'(MIN_GREEN);
    localparam logic [CNT_W:0] YELLOW_T  = (CNT_W+1)'(YELLOW_TIME);
    localparam logic [CNT_W:0] ALL_RED_T = (CNT_W+1)'(ALL_RED_TIME);
    localparam logic [CNT_W:0] WALK_T    = (CNT_W+1)'(WALK_TIME);

    phase_t           state;
    phase_t           next_state;
    logic [CNT_W-1:0] sec_cnt;
    logic [CNT_W:0]   sec_next;
    logic             ped_pend_ns, ped_pend_ew;
    logic             next_pend_ns, next_pend_ew;
    logic             flash_on, next_flash_on;
    logic             walk_ns_q, walk_ew_q, next_walk_ns, next_walk_ew;
    lamp_t            ns_lamp_q, ew_lamp_q, next_ns_lamp, next_ew_lamp;
    logic             enter_ns, enter_ew, walk_end;

    traffic_phase_fsm_phase_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (next_state != state),
        .tick    (bus.one_sec),
        .sec_cnt (sec_cnt)
    );

    // Compare against sec_cnt+1 so a timed exit lands on the tick that completes the duration.
    assign sec_next = {1'b0, sec_cnt} + (CNT_W+1)'(1);

    always_comb begin
        next_state = state;
        case (state)
            ALL_RED_A: begin
                if (bus.one_sec && (sec_next >= ALL_RED_T))
                    next_state = bus.flash_mode ? FLASH : NS_GREEN;
            end
            NS_GREEN: begin
                if (bus.flash_mode)
                    next_state = NS_YELLOW;
                else if (bus.one_sec && (bus.ew_car || ped_pend_ew) &&
                         ((sec_next >= GREEN_T) || (ped_pend_ew && (sec_next >= MIN_T))))
                    next_state = NS_YELLOW;
            end
            NS_YELLOW: begin
                if (bus.one_sec && (sec_next >= YELLOW_T))
                    next_state = ALL_RED_B;
            end
            ALL_RED_B: begin
                if (bus.one_sec && (sec_next >= ALL_RED_T))
                    next_state = bus.flash_mode ? FLASH : EW_GREEN;
            end
            EW_GREEN: begin
                if (bus.flash_mode || (bus.one_sec && (sec_next >= GREEN_T)))
                    next_state = EW_YELLOW;
            end
            EW_YELLOW: begin
                if (bus.one_sec && (sec_next >= YELLOW_T))
                    next_state = ALL_RED_A;
            end
            FLASH: begin
                if (!bus.flash_mode)
                    next_state = ALL_RED_A;
            end
            default: next_state = ALL_RED_A;
        endcase
    end

    // Ped latches, walk windows and flash phase; outputs are precomputed from the next state.
    always_comb begin
        enter_ns      = (next_state == NS_GREEN) && (state != NS_GREEN);
        enter_ew      = (next_state == EW_GREEN) && (state != EW_GREEN);
        walk_end      = bus.one_sec && (sec_next >= WALK_T);
        next_pend_ns  = enter_ns ? 1'b0 : (ped_pend_ns | bus.ped_req_ns);
        next_pend_ew  = enter_ew ? 1'b0 : (ped_pend_ew | bus.ped_req_ew);
        next_walk_ns  = (next_state == NS_GREEN) &&
                        (enter_ns ? ped_pend_ns : (walk_ns_q && !walk_end));
        next_walk_ew  = (next_state == EW_GREEN) &&
                        (enter_ew ? ped_pend_ew : (walk_ew_q && !walk_end));
        next_flash_on = ((state == FLASH) && (next_state == FLASH)) ? (flash_on ^ bus.half_sec) : 1'b0;
        next_ns_lamp  = LAMP_RED;
        next_ew_lamp  = LAMP_RED;
        case (next_state)
            NS_GREEN:  next_ns_lamp = LAMP_GRN;
            NS_YELLOW: next_ns_lamp = LAMP_YEL;
            EW_GREEN:  next_ew_lamp = LAMP_GRN;
            EW_YELLOW: next_ew_lamp = LAMP_YEL;
            FLASH: begin
                next_ns_lamp = next_flash_on ? LAMP_YEL : LAMP_OFF;
                next_ew_lamp = next_flash_on ? LAMP_RED : LAMP_OFF;
            end
            default: begin
                next_ns_lamp = LAMP_RED;
                next_ew_lamp = LAMP_RED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ALL_RED_A;
            ped_pend_ns <= 1'b0;
            ped_pend_ew <= 1'b0;
            flash_on    <= 1'b0;
            walk_ns_q   <= 1'b0;
            walk_ew_q   <= 1'b0;
            ns_lamp_q   <= LAMP_RED;
            ew_lamp_q   <= LAMP_RED;
        end else begin
            state       <= next_state;
            ped_pend_ns <= next_pend_ns;
            ped_pend_ew <= next_pend_ew;
            flash_on    <= next_flash_on;
            walk_ns_q   <= next_walk_ns;
            walk_ew_q   <= next_walk_ew;
            ns_lamp_q   <= next_ns_lamp;
            ew_lamp_q   <= next_ew_lamp;
        end
    end

    assign bus.ns_lamp = ns_lamp_q;
    assign bus.ew_lamp = ew_lamp_q;
    assign bus.walk_ns = walk_ns_q;
    assign bus.walk_ew = walk_ew_q;
    assign bus.phase   = state;

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Bench for traffic_phase_fsm: directed scenarios plus random demand, every cycle
// compared against a rotation-table model of the intersection.
module tb_traffic_phase_fsm;
    import traffic_phase_fsm_pkg::*;

    localparam int GREEN_TIME   = 20;
    localparam int MIN_GREEN    = 5;
    localparam int YELLOW_TIME  = 3;
    localparam int ALL_RED_TIME = 1;
    localparam int WALK_TIME    = 7;
    localparam int SEC_CLKS     = 10;
    localparam int HALF_CLKS    = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    traffic_phase_fsm_if bus();

    traffic_phase_fsm #(
        .GREEN_TIME   (GREEN_TIME),
        .MIN_GREEN    (MIN_GREEN),
        .YELLOW_TIME  (YELLOW_TIME),
        .ALL_RED_TIME (ALL_RED_TIME),
        .WALK_TIME    (WALK_TIME)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model: position in the six-step rotation, or flashing, plus elapsed seconds.
    int     m_idx, m_sec, m_walk_ns, m_walk_ew;
    bit     m_flashing, m_flash_on, m_pend_ns, m_pend_ew;
    int     dur_tab[6]     = '{ALL_RED_TIME, GREEN_TIME, YELLOW_TIME, ALL_RED_TIME, GREEN_TIME, YELLOW_TIME};
    lamp_t  ns_tab[6]      = '{LAMP_RED, LAMP_GRN, LAMP_YEL, LAMP_RED, LAMP_RED, LAMP_RED};
    lamp_t  ew_tab[6]      = '{LAMP_RED, LAMP_RED, LAMP_RED, LAMP_RED, LAMP_GRN, LAMP_YEL};
    phase_t phase_tab[6]   = '{ALL_RED_A, NS_GREEN, NS_YELLOW, ALL_RED_B, EW_GREEN, EW_YELLOW};

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("[TB] FAIL %s cycle %0d: got %b, want %b", tag, cyc, got, want);
    endtask

    task automatic model_reset();
        m_idx = 0; m_sec = 0; m_walk_ns = 0; m_walk_ew = 0;
        m_flashing = 1'b0; m_flash_on = 1'b0; m_pend_ns = 1'b0; m_pend_ew = 1'b0;
    endtask

    task automatic model_step(input bit rst, input bit tick, input bit half, input bit car,
                              input bit rq_ns, input bit rq_ew, input bit fm);
        bit leave;
        leave = 1'b0;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_flashing) begin
            m_flash_on = m_flash_on ^ half;
            m_pend_ns |= rq_ns;
            m_pend_ew |= rq_ew;
            if (!fm) begin
                m_flashing = 1'b0; m_flash_on = 1'b0; m_idx = 0; m_sec = 0;
            end
            return;
        end
        if ((m_idx == 1 || m_idx == 4) && fm) leave = 1'b1;
        else if (tick) begin
            if (m_idx == 1)
                leave = (car || m_pend_ew) &&
                        ((m_sec + 1 >= GREEN_TIME) || (m_pend_ew && (m_sec + 1 >= MIN_GREEN)));
            else
                leave = (m_sec + 1 >= dur_tab[m_idx]);
        end
        if (tick && m_walk_ns > 0) m_walk_ns--;
        if (tick && m_walk_ew > 0) m_walk_ew--;
        if (!leave) begin
            if (tick) m_sec++;
            m_pend_ns |= rq_ns;
            m_pend_ew |= rq_ew;
            return;
        end
        m_sec = 0; m_walk_ns = 0; m_walk_ew = 0;
        if ((m_idx == 0 || m_idx == 3) && fm) begin
            m_flashing = 1'b1; m_flash_on = 1'b0;
            m_pend_ns |= rq_ns; m_pend_ew |= rq_ew;
        end else begin
            m_idx = (m_idx + 1) % 6;
            if (m_idx == 1) begin
                m_walk_ns = m_pend_ns ? WALK_TIME : 0;
                m_pend_ns = 1'b0;
                m_pend_ew |= rq_ew;
            end else if (m_idx == 4) begin
                m_walk_ew = m_pend_ew ? WALK_TIME : 0;
                m_pend_ew = 1'b0;
                m_pend_ns |= rq_ns;
            end else begin
                m_pend_ns |= rq_ns; m_pend_ew |= rq_ew;
            end
        end
    endtask

    task automatic check_all();
        lamp_t  e_ns, e_ew;
        phase_t e_ph;
        if (m_flashing) begin
            e_ns = m_flash_on ? LAMP_YEL : LAMP_OFF;
            e_ew = m_flash_on ? LAMP_RED : LAMP_OFF;
            e_ph = FLASH;
        end else begin
            e_ns = ns_tab[m_idx];
            e_ew = ew_tab[m_idx];
            e_ph = phase_tab[m_idx];
        end
        checkOutput("ns_lamp", {5'b0, bus.ns_lamp}, {5'b0, e_ns});
        checkOutput("ew_lamp", {5'b0, bus.ew_lamp}, {5'b0, e_ew});
        checkOutput("walk_ns", {7'b0, bus.walk_ns}, {7'b0, (m_walk_ns > 0)});
        checkOutput("walk_ew", {7'b0, bus.walk_ew}, {7'b0, (m_walk_ew > 0)});
        checkOutput("phase",   {5'b0, bus.phase},   {5'b0, e_ph});
    endtask

    // One clock: check what the last edge produced, then drive the next inputs.
    task automatic applyStimulus(input bit rst, input bit car, input bit rq_ns,
                                 input bit rq_ew, input bit fm);
        bit tick, half;
        @(negedge clk);
        check_all();
        tick = ((cyc % SEC_CLKS) == SEC_CLKS - 1);
        half = ((cyc % HALF_CLKS) == HALF_CLKS - 1);
        reset          = rst;
        bus.one_sec    = tick;
        bus.half_sec   = half;
        bus.ew_car     = car;
        bus.ped_req_ns = rq_ns;
        bus.ped_req_ew = rq_ew;
        bus.flash_mode = fm;
        model_step(rst, tick, half, car, rq_ns, rq_ew, fm);
        cyc++;
    endtask

    task automatic run_until(input string tag, input int idx, input int sec,
                             input bit car, input int budget);
        bit reached;
        reached = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!m_flashing && m_idx == idx && m_sec == sec) begin
                reached = 1'b1;
                break;
            end
            applyStimulus(1'b0, car, 1'b0, 1'b0, 1'b0);
        end
        checkOutput(tag, {7'b0, reached}, 8'd1);
    endtask

    initial begin
        bit car, fm, rn, re, rs;
        bus.one_sec = 1'b0; bus.half_sec = 1'b0; bus.ped_req_ns = 1'b0;
        bus.ped_req_ew = 1'b0; bus.ew_car = 1'b0; bus.flash_mode = 1'b0;
        model_reset();
        $display("[TB] start");

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 1100; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 500; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_until("wait_ns_green_sec2", 1, 2, 1'b0, 500);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 400; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_until("wait_ew_green_sec4", 4, 4, 1'b1, 1500);
        for (int i = 0; i < 200; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_until("wait_ew_yellow_sec1", 5, 1, 1'b1, 1500);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        car = 1'b0; fm = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(199) == 0) car = ~car;
            if (fm) fm = ($urandom_range(399) != 0);
            else    fm = ($urandom_range(3999) == 0);
            rn = ($urandom_range(249) == 0);
            re = ($urandom_range(249) == 0);
            rs = ($urandom_range(4999) == 0);
            applyStimulus(rs, car, rn, re, fm);
        end
        @(negedge clk);
        check_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
